// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared constants, state encoding and matrix packing helpers
package systolic_pkg;

  localparam int DIM    = 4;
  localparam int ELEM_W = 8;
  localparam int MAT_W  = DIM * DIM * ELEM_W;
  localparam int VEC_W  = DIM * ELEM_W;
  localparam int K_W    = $clog2(DIM);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    OUT
  } state_t;

  // Row-major packing: element (i,j) sits at the top of the word for (0,0).
  function automatic logic [ELEM_W-1:0] elem(input logic [MAT_W-1:0] mat,
                                             input int i, input int j);
    return mat[MAT_W-1-ELEM_W*(DIM*i+j) -: ELEM_W];
  endfunction

  function automatic logic [MAT_W-1:0] set_elem(input logic [MAT_W-1:0] mat,
                                                input int i, input int j,
                                                input logic [ELEM_W-1:0] v);
    logic [MAT_W-1:0] r;
    r = mat;
    r[MAT_W-1-ELEM_W*(DIM*i+j) -: ELEM_W] = v;
    return r;
  endfunction

endpackage

// File: rtl/systolic_operand_sel.sv
// rtl/systolic_operand_sel.sv - picks column k of A and row k of B for one feed cycle
module systolic_operand_sel
  import systolic_pkg::*;
(
  input  logic [MAT_W-1:0] a,
  input  logic [MAT_W-1:0] b,
  input  logic [K_W-1:0]   k,
  output logic [VEC_W-1:0] col_a,
  output logic [VEC_W-1:0] row_b
);

  always_comb begin
    col_a = '0;
    row_b = '0;
    for (int n = 0; n < DIM; n++) begin
      col_a[VEC_W-1-ELEM_W*n -: ELEM_W] = elem(a, n, int'(k));
      row_b[VEC_W-1-ELEM_W*n -: ELEM_W] = elem(b, int'(k), n);
    end
  end

endmodule

// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - job sequencer: accept A/B, clear and feed the array, return C
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int DRAIN_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [MAT_W-1:0]   s_a,
  input  logic [MAT_W-1:0]   s_b,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [MAT_W-1:0]   m_result,
  output logic               m_error,
  output logic               arr_rst_n,
  output logic [VEC_W-1:0]   arr_matrixA,
  output logic [VEC_W-1:0]   arr_matrixB,
  output logic               arr_valid_in,
  input  logic [MAT_W-1:0]   arr_result,
  input  logic               arr_valid_out
);

  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

  state_t           state;
  logic [K_W:0]     k;
  logic [TW-1:0]    tcnt;
  logic [MAT_W-1:0] a_q;
  logic [MAT_W-1:0] b_q;
  logic [VEC_W-1:0] col_a;
  logic [VEC_W-1:0] row_b;

  assign s_ready = (state == IDLE) && reset;

  systolic_operand_sel u_sel (
    .a     (a_q),
    .b     (b_q),
    .k     (k[K_W-1:0]),
    .col_a (col_a),
    .row_b (row_b)
  );

  // k counts columns already issued; it reaches DIM on the last FEED cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      k            <= '0;
      tcnt         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      arr_rst_n    <= 1'b0;
      arr_valid_in <= 1'b0;
      arr_matrixA  <= '0;
      arr_matrixB  <= '0;
      m_valid      <= 1'b0;
      m_error      <= 1'b0;
      m_result     <= '0;
    end else begin
      case (state)
        IDLE: begin
          arr_rst_n <= 1'b1;
          if (s_valid) begin
            a_q       <= s_a;
            b_q       <= s_b;
            k         <= '0;
            arr_rst_n <= 1'b0;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          arr_rst_n    <= 1'b1;
          arr_valid_in <= 1'b1;
          arr_matrixA  <= col_a;
          arr_matrixB  <= row_b;
          k            <= k + 1'b1;
          state        <= FEED;
        end
        FEED: begin
          if (k == (K_W+1)'(DIM)) begin
            arr_valid_in <= 1'b0;
            arr_matrixA  <= '0;
            arr_matrixB  <= '0;
            tcnt         <= '0;
            state        <= DRAIN;
          end else begin
            arr_matrixA <= col_a;
            arr_matrixB <= row_b;
            k           <= k + 1'b1;
          end
        end
        DRAIN: begin
          if (arr_valid_out) begin
            m_result <= arr_result;
            m_error  <= 1'b0;
            m_valid  <= 1'b1;
            state    <= OUT;
          end else if (tcnt == TW'(DRAIN_TIMEOUT - 1)) begin
            m_result <= '0;
            m_error  <= 1'b1;
            m_valid  <= 1'b1;
            state    <= OUT;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
